// File: rtl/core_defs.sv
// Shared definitions for the fetch-PC generator: default widths, reset vector,
// FSM state encoding and the legal fetch alignments.
package core_defs;

    localparam int          ADDR_W_DEF     = 32;
    localparam logic [31:0] RESET_ADDR_DEF = 32'h0000_0000;

    // Legal fetch step / alignment values in bytes
    localparam int IALIGN_HALF = 2;
    localparam int IALIGN_WORD = 4;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_ERR  = 2'd2
    } pc_state_e;

    function automatic logic ialign_legal(input int ialign);
        return (ialign == IALIGN_HALF) || (ialign == IALIGN_WORD);
    endfunction

endpackage

// File: rtl/pc_redirect_buf.sv
// Holds one redirect that arrived while a fetch was waiting for its grant.
// A trap replaces a buffered jump; a jump never replaces a buffered trap.
// The buffer empties on the next fetch-address step.
module pc_redirect_buf #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              consume_i,
    input  logic              cap_trap_i,
    input  logic [ADDR_W-1:0] trap_addr_i,
    input  logic              cap_jump_i,
    input  logic [ADDR_W-1:0] jump_addr_i,
    output logic              pend_vld_o,
    output logic [ADDR_W-1:0] pend_addr_o
);

    logic              pend_vld_q;
    logic              pend_trap_q;
    logic [ADDR_W-1:0] pend_addr_q;

    // Capture/overwrite/drain of the single pending redirect entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_vld_q  <= 1'b0;
            pend_trap_q <= 1'b0;
            pend_addr_q <= '0;
        end else if (consume_i) begin
            pend_vld_q  <= 1'b0;
            pend_trap_q <= 1'b0;
        end else if (cap_trap_i) begin
            pend_vld_q  <= 1'b1;
            pend_trap_q <= 1'b1;
            pend_addr_q <= trap_addr_i;
        end else if (cap_jump_i && !(pend_vld_q && pend_trap_q)) begin
            pend_vld_q  <= 1'b1;
            pend_trap_q <= 1'b0;
            pend_addr_q <= jump_addr_i;
        end
    end

    assign pend_vld_o  = pend_vld_q;
    assign pend_addr_o = pend_addr_q;

endmodule

// File: rtl/pc_gen.sv
// Fetch-PC generator: BOOT/RUN/ERR sequencing, next-PC selection with
// trap > jump > buffered redirect > hold > increment priority, and a req/gnt
// handshake that keeps the address stable until a pending fetch is granted.
module pc_gen
    import core_defs::*;
#(
    parameter int                ADDR_W     = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(RESET_ADDR_DEF),
    parameter int                HOLD_W     = 3,
    parameter int                IALIGN     = IALIGN_WORD
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [HOLD_W-1:0] hold_flag_i,
    input  logic              jump_flag_i,
    input  logic [ADDR_W-1:0] jump_addr_i,
    input  logic              trap_flag_i,
    input  logic [ADDR_W-1:0] trap_addr_i,
    output logic              ifu_req_o,
    output logic [ADDR_W-1:0] ifu_addr_o,
    input  logic              ifu_gnt_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic              misalign_o,
    output logic [ADDR_W-1:0] misalign_addr_o
);

    if (!ialign_legal(IALIGN)) begin : g_bad_ialign
        $error("pc_gen: IALIGN must be 2 or 4");
    end
    if (RESET_ADDR[0] || ((IALIGN == IALIGN_WORD) && RESET_ADDR[1])) begin : g_bad_reset_addr
        $error("pc_gen: RESET_ADDR is not aligned to IALIGN");
    end

    pc_state_e         state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              outstanding_q;
    logic              misalign_q;
    logic [ADDR_W-1:0] misalign_addr_q;

    logic              hold;
    logic              req;
    logic              stall;
    logic              step;
    logic              jump_misaligned;
    logic              jump_ok;
    logic              mis_jump;
    logic              pend_vld;
    logic [ADDR_W-1:0] pend_addr;

    assign hold  = |hold_flag_i;
    // An ungranted request stays up even through a hold or an error entry.
    assign req   = outstanding_q | ((state_q == ST_RUN) & ~hold);
    assign stall = req & ~ifu_gnt_i;
    assign step  = ~stall & ((state_q == ST_RUN) | ((state_q == ST_ERR) & trap_flag_i));

    assign jump_misaligned = (IALIGN == IALIGN_WORD) ? (jump_addr_i[1:0] != 2'b00)
                                                     : jump_addr_i[0];
    assign jump_ok  = (state_q == ST_RUN) & jump_flag_i & ~trap_flag_i & ~jump_misaligned;
    assign mis_jump = (state_q == ST_RUN) & jump_flag_i & ~trap_flag_i &  jump_misaligned;

    pc_redirect_buf #(
        .ADDR_W (ADDR_W)
    ) u_redirect_buf (
        .clk         (clk),
        .rst         (rst),
        .consume_i   (step),
        .cap_trap_i  (stall & trap_flag_i & (state_q != ST_BOOT)),
        .trap_addr_i (trap_addr_i),
        .cap_jump_i  (stall & jump_ok),
        .jump_addr_i (jump_addr_i),
        .pend_vld_o  (pend_vld),
        .pend_addr_o (pend_addr)
    );

    // Next-state and next-PC selection
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        unique case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN:  if (mis_jump) state_d = ST_ERR;
            ST_ERR:  if (trap_flag_i) state_d = ST_RUN;
            default: state_d = ST_BOOT;
        endcase
        if (step) begin
            if (trap_flag_i) begin
                pc_d = trap_addr_i;
            end else if (jump_ok) begin
                pc_d = jump_addr_i;
            end else if (mis_jump) begin
                pc_d = pc_q;
            end else if (pend_vld) begin
                pc_d = pend_addr;
            end else if (hold) begin
                pc_d = pc_q;
            end else begin
                pc_d = pc_q + ADDR_W'(IALIGN);
            end
        end
    end

    // State, PC, handshake tracking and misalignment report registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= ST_BOOT;
            pc_q            <= RESET_ADDR;
            outstanding_q   <= 1'b0;
            misalign_q      <= 1'b0;
            misalign_addr_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            outstanding_q <= stall;
            misalign_q    <= mis_jump;
            if (mis_jump) begin
                misalign_addr_q <= jump_addr_i;
            end
        end
    end

    assign ifu_req_o       = req;
    assign ifu_addr_o      = pc_q;
    assign pc_o            = pc_q;
    assign misalign_o      = misalign_q;
    assign misalign_addr_o = misalign_addr_q;

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: one IALIGN=4 instance and one IALIGN=2 instance
// driven from the same stimulus; each phase checks the instance it targets.
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  hold;
    logic        jump;
    logic [31:0] jaddr;
    logic        trap;
    logic [31:0] taddr;
    logic        gnt;

    logic        req4, mis4, req2, mis2;
    logic [31:0] addr4, pc4, misa4, addr2, pc2, misa2;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pc_gen #(.ADDR_W(32), .RESET_ADDR(32'h0), .HOLD_W(3), .IALIGN(4)) dut4 (
        .clk(clk), .rst(rst), .hold_flag_i(hold),
        .jump_flag_i(jump), .jump_addr_i(jaddr),
        .trap_flag_i(trap), .trap_addr_i(taddr),
        .ifu_req_o(req4), .ifu_addr_o(addr4), .ifu_gnt_i(gnt),
        .pc_o(pc4), .misalign_o(mis4), .misalign_addr_o(misa4)
    );

    pc_gen #(.ADDR_W(32), .RESET_ADDR(32'h0), .HOLD_W(3), .IALIGN(2)) dut2 (
        .clk(clk), .rst(rst), .hold_flag_i(hold),
        .jump_flag_i(jump), .jump_addr_i(jaddr),
        .trap_flag_i(trap), .trap_addr_i(taddr),
        .ifu_req_o(req2), .ifu_addr_o(addr2), .ifu_gnt_i(gnt),
        .pc_o(pc2), .misalign_o(mis2), .misalign_addr_o(misa2)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst = 1'b0; hold = 3'b000; jump = 1'b0; jaddr = '0;
        trap = 1'b0; taddr = '0; gnt = 1'b1;
        #1 rst = 1'b1;
        #1;
        check_val("rst_req",      {31'b0, req4}, 32'h0);
        check_val("rst_pc",       pc4,           32'h0);
        check_val("rst_mis",      {31'b0, mis4}, 32'h0);
        check_val("rst_mis_addr", misa4,         32'h0);
        tick(); tick();
        rst = 1'b0; settle();
        check_val("boot_req", {31'b0, req4}, 32'h0);
        check_val("boot_pc",  addr4,         32'h0);

        // 1: fetch stream with gnt tied high
        tick();
        check_val("t1_req",   {31'b0, req4}, 32'h1);
        check_val("t1_addr0", addr4,         32'h0);
        check_val("t1_pc_eq", pc4,           32'h0);
        tick();
        check_val("t1_addr4", addr4, 32'h4);
        tick();
        check_val("t1_addr8", addr4, 32'h8);

        // 2: hold while ungranted keeps req and address, then PC holds
        gnt = 1'b0; tick();
        hold = 3'b010; settle();
        check_val("t2_req_ungranted",  {31'b0, req4}, 32'h1);
        check_val("t2_addr_ungranted", addr4,         32'h8);
        tick();
        check_val("t2_req_still", {31'b0, req4}, 32'h1);
        check_val("t2_addr_still", addr4,        32'h8);
        gnt = 1'b1; tick();
        check_val("t2_req_held", {31'b0, req4}, 32'h0);
        check_val("t2_pc_held",  pc4,           32'h8);
        tick();
        check_val("t2_pc_held2", pc4, 32'h8);
        hold = 3'b000; settle();
        check_val("t2_req_resume", {31'b0, req4}, 32'h1);
        tick();
        check_val("t2_addr_c", addr4, 32'hC);

        // 3: jump buffered while ungranted, lands the cycle after the grant
        gnt = 1'b0; tick();
        jump = 1'b1; jaddr = 32'h100; tick();
        jump = 1'b0; settle();
        check_val("t3_addr_stable", addr4, 32'hC);
        check_val("t3_req",         {31'b0, req4}, 32'h1);
        gnt = 1'b1; tick();
        check_val("t3_addr_jump", addr4, 32'h100);

        // 4: trap overwrites pending jump; later jump cannot overwrite pending trap
        gnt = 1'b0; jump = 1'b1; jaddr = 32'h100; tick();
        jump = 1'b0; trap = 1'b1; taddr = 32'h200; tick();
        trap = 1'b0; jump = 1'b1; jaddr = 32'h300; tick();
        jump = 1'b0; settle();
        check_val("t4_addr_stable", addr4, 32'h100);
        gnt = 1'b1; tick();
        check_val("t4_trap_pend", addr4, 32'h200);
        trap = 1'b1; taddr = 32'h280; jump = 1'b1; jaddr = 32'h300; tick();
        trap = 1'b0; jump = 1'b0; settle();
        check_val("t4_trap_wins", addr4, 32'h280);
        // fresh redirect on the loading step drops the buffered one
        gnt = 1'b0; jump = 1'b1; jaddr = 32'h500; tick();
        gnt = 1'b1; jaddr = 32'h600; tick();
        jump = 1'b0; settle();
        check_val("t4_new_wins", addr4, 32'h600);
        tick();
        check_val("t4_pend_dropped", addr4, 32'h604);

        // 5: misaligned jump -> ERR, then trap recovers
        jump = 1'b1; jaddr = 32'h102; tick();
        jump = 1'b0; settle();
        check_val("t5_mis_pulse", {31'b0, mis4}, 32'h1);
        check_val("t5_mis_addr",  misa4,         32'h102);
        check_val("t5_pc_kept",   pc4,           32'h604);
        check_val("t5_req_low",   {31'b0, req4}, 32'h0);
        tick();
        check_val("t5_mis_done",  {31'b0, mis4}, 32'h0);
        check_val("t5_mis_held",  misa4,         32'h102);
        check_val("t5_req_err",   {31'b0, req4}, 32'h0);
        check_val("t5_pc_err",    pc4,           32'h604);
        trap = 1'b1; taddr = 32'h80; tick();
        trap = 1'b0; settle();
        check_val("t5_trap_addr", addr4,         32'h80);
        check_val("t5_trap_req",  {31'b0, req4}, 32'h1);

        // 6: wraparound at the top of the address space
        jump = 1'b1; jaddr = 32'hFFFF_FFFC; tick();
        jump = 1'b0; settle();
        check_val("t6_top", pc4, 32'hFFFF_FFFC);
        tick();
        check_val("t6_wrap", pc4, 32'h0);

        // reset during an ungranted fetch with a buffered jump
        gnt = 1'b0; jump = 1'b1; jaddr = 32'h40; tick();
        jump = 1'b0; settle();
        check_val("rst_pre_req", {31'b0, req4}, 32'h1);
        rst = 1'b1; settle();
        check_val("rst_abort_req", {31'b0, req4}, 32'h0);
        check_val("rst_abort_pc",  pc4,           32'h0);

        // IALIGN=2 build
        gnt = 1'b1; tick();
        rst = 1'b0; settle();
        tick();
        check_val("h2_addr0", pc2,           32'h0);
        check_val("h2_req",   {31'b0, req2}, 32'h1);
        tick();
        check_val("h2_addr2", pc2, 32'h2);
        check_val("rst_pend_discarded", pc4, 32'h4);
        tick();
        check_val("h2_addr4", pc2, 32'h4);
        jump = 1'b1; jaddr = 32'h102; tick();
        jump = 1'b0; settle();
        check_val("h2_jump_102", pc2,           32'h102);
        check_val("h2_no_mis",   {31'b0, mis2}, 32'h0);
        tick();
        check_val("h2_step_104", pc2, 32'h104);
        jump = 1'b1; jaddr = 32'h105; tick();
        jump = 1'b0; settle();
        check_val("h2_mis_pulse", {31'b0, mis2}, 32'h1);
        check_val("h2_mis_addr",  misa2,         32'h105);
        check_val("h2_req_low",   {31'b0, req2}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
